// File: rtl/ram_dump_uart_if.sv
// ram_dump_uart_if: start handshake, RAM read port and UART/status lines of the RAM dumper.
// master = the dumper itself (drives the RAM address and the serial line),
// slave  = the surrounding system (issues start, returns RAM read data).
interface ram_dump_uart_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  mem_rdata,
    output mem_addr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output mem_rdata,
    input  mem_addr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/ram_dump_uart.sv
// ram_dump_uart: on a start pulse, reads RAM bytes 0..DEPTH-1 through a registered
// read port and sends each one over an 8N1 UART line, LSB first.
// Build option: define DUMP_HEADER_EN to prefix every dump with two framed header
// bytes (sync 0xA5, then DEPTH[7:0]); without it no header logic exists.
module ram_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 65
) (
  input  logic            clk,
  input  logic            reset,
  ram_dump_uart_if.master bus
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef DUMP_HEADER_EN
  localparam logic [DATA_W-1:0] HDR_SYNC_BYTE = 8'hA5;
  localparam logic [DATA_W-1:0] HDR_LEN_BYTE  = DATA_W'(DEPTH);

  // Which frame is on the wire: a header byte or RAM data.
  localparam logic [1:0] PH_DATA = 2'd0;
  localparam logic [1:0] PH_SYNC = 2'd1;
  localparam logic [1:0] PH_LEN  = 2'd2;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_DONE
`ifdef DUMP_HEADER_EN
    ,
    S_HDR_SYNC,
    S_HDR_LEN
`endif
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shift_reg;
  logic                tx_r;
  logic                busy_r;
  logic                done_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                baud_last_c;
`ifdef DUMP_HEADER_EN
  logic [1:0]          hdr_phase;
`endif

  assign baud_last_c  = (baud_cnt == BAUD_LAST);

  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.mem_addr = mem_addr_r;

  // Dump sequencer: address walk, RAM capture and UART bit framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_addr_r <= '0;
`ifdef DUMP_HEADER_EN
      hdr_phase  <= PH_DATA;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_r     <= 1'b1;
          busy_r   <= 1'b0;
          baud_cnt <= '0;
          if (bus.start) begin
            busy_r   <= 1'b1;
            addr_cnt <= '0;
`ifdef DUMP_HEADER_EN
            state      <= S_HDR_SYNC;
`else
            mem_addr_r <= '0;
            state      <= S_FETCH;
`endif
          end
        end

        // mem_addr was set on entry; the RAM registers it at the end of this cycle.
        S_FETCH: begin
          state <= S_LOAD;
        end

        S_LOAD: begin
          shift_reg <= bus.mem_rdata;
          tx_r      <= 1'b0;
          state     <= S_START_BIT;
        end

`ifdef DUMP_HEADER_EN
        S_HDR_SYNC: begin
          shift_reg <= HDR_SYNC_BYTE;
          hdr_phase <= PH_SYNC;
          tx_r      <= 1'b0;
          state     <= S_START_BIT;
        end

        S_HDR_LEN: begin
          shift_reg <= HDR_LEN_BYTE;
          tx_r      <= 1'b0;
          state     <= S_START_BIT;
        end
`endif

        S_START_BIT: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_r     <= shift_reg[0];
            state    <= S_DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        // The bit on the line is always shift_reg[0]; the next one is shift_reg[1].
        S_DATA_BITS: begin
          if (baud_last_c) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
            if (bit_idx == BIT_LAST) begin
              tx_r  <= 1'b1;
              state <= S_STOP_BIT;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              tx_r    <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_STOP_BIT: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
`ifdef DUMP_HEADER_EN
            if (hdr_phase == PH_SYNC) begin
              hdr_phase <= PH_LEN;
              state     <= S_HDR_LEN;
            end else if (hdr_phase == PH_LEN) begin
              hdr_phase  <= PH_DATA;
              mem_addr_r <= addr_cnt;
              state      <= S_FETCH;
            end else
`endif
            if (addr_cnt == ADDR_LAST) begin
              done_r <= 1'b1;
              state  <= S_DONE;
            end else begin
              addr_cnt   <= addr_cnt + ADDR_W'(1);
              mem_addr_r <= addr_cnt + ADDR_W'(1);
              state      <= S_FETCH;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        // start is deliberately not looked at here; IDLE picks it up next cycle.
        S_DONE: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_uart.sv
// tb_ram_dump_uart: directed bench for ram_dump_uart with a registered RAM model
// and a UART receiver that decodes every frame on tx.
module tb_ram_dump_uart;

  localparam int C = 4;
  localparam int D = 4;

`ifdef DUMP_HEADER_EN
  localparam int HDR_N   = 2;
  localparam int FALL_K  = 1;
`else
  localparam int HDR_N   = 0;
  localparam int FALL_K  = 2;
`endif
  localparam int HDR_CYC = HDR_N * (1 + 10 * C);
  localparam int NB      = D + HDR_N;
  localparam int DONE_K  = HDR_CYC + D * (2 + 10 * C);
  localparam int WR_K    = HDR_CYC + (2 + 10 * C) + 18;
  localparam int RST_K   = 100;

  logic clk = 1'b0;
  logic reset;

  ram_dump_uart_if bus();

  ram_dump_uart #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Registered RAM read port model.
  logic [7:0] ram [256];
  always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

  // UART receiver / activity monitor, sampled on the falling edge.
  logic [7:0] rx_q [$];
  int         done_cnt  = 0;
  int         frame_bad = 0;
  bit         in_frame  = 1'b0;
  int         off       = 0;
  logic [7:0] sh        = 8'd0;
  logic [7:0] max_addr  = 8'd0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.mem_addr > max_addr) max_addr = bus.mem_addr;
    if (reset === 1'b1) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && bus.tx === 1'b0) begin
        in_frame = 1'b1;
        off      = 0;
      end else if (in_frame) begin
        off++;
      end
      if (in_frame) begin
        if (off < C) begin
          if (bus.tx !== 1'b0) frame_bad++;
        end else if (off < 9 * C) begin
          if ((off % C) == (C / 2)) sh = {bus.tx, sh[7:1]};
        end else begin
          if (bus.tx !== 1'b1) frame_bad++;
          if (off == 10 * C - 1) begin
            rx_q.push_back(sh);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [3:0][7:0] ram;
    logic            wr_en;
    logic [7:0]      wr_addr;
    logic [7:0]      wr_data;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [3];
  int   checks;
  int   errors;

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic we, input logic [7:0] wa, input logic [7:0] wd,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    vec_t r;
    r.ram     = {b3, b2, b1, b0};
    r.wr_en   = we;
    r.wr_addr = wa;
    r.wr_data = wd;
    r.exp     = {e3, e2, e1, e0};
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int v, input int j);
    if (j < HDR_N) return (j == 0) ? 8'hA5 : 8'(D);
    return vecs[v].exp[j - HDR_N];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bytes(input int v, input int base, input int n);
    for (int j = 0; j < n; j++) begin
      int act;
      act = (base + j < rx_q.size()) ? int'(rx_q[base + j]) : -1;
      chk($sformatf("rx_byte%0d_vec%0d", j, v), act, int'(exp_byte(v, j)));
    end
  endtask

  task automatic load_ram(input int v);
    for (int a = 0; a < D; a++) ram[a] = vecs[v].ram[a];
  endtask

  // Called at the falling edge just after the accepting edge (k = 0).
  task automatic observe(input int wr_k, input logic [7:0] wa, input logic [7:0] wd,
                         output int fall_k, output int done_k, output int busy_done);
    fall_k    = -1;
    done_k    = -1;
    busy_done = -1;
    for (int k = 0; k <= DONE_K + 10; k++) begin
      if (k > 0) @(negedge clk);
      if (fall_k < 0 && bus.tx === 1'b0) fall_k = k;
      if (k == wr_k) ram[wa] = wd;
      if (bus.done === 1'b1) begin
        done_k    = k;
        busy_done = int'(bus.busy);
        break;
      end
    end
  endtask

  task automatic run_vec(input int v);
    int base, dc0, fall_k, done_k, bd;
    base = rx_q.size();
    dc0  = done_cnt;
    load_ram(v);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("busy_on_accept", int'(bus.busy), 1);
    observe(vecs[v].wr_en ? WR_K : -1, vecs[v].wr_addr, vecs[v].wr_data, fall_k, done_k, bd);
    chk("tx_fall_latency", fall_k, FALL_K);
    chk("done_latency", done_k, DONE_K);
    chk("busy_at_done", bd, 1);
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("done_one_cycle", int'(bus.done), 0);
    chk("tx_idle_after", int'(bus.tx), 1);
    chk("done_count", done_cnt - dc0, 1);
    chk("rx_count", rx_q.size() - base, NB);
    check_bytes(v, base, NB);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, dc0, fall_k, done_k, bd;
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;

    vecs[0] = mk(8'h55, 8'h00, 8'hFF, 8'h81, 1'b0, 8'd0, 8'h00, 8'h55, 8'h00, 8'hFF, 8'h81);
    vecs[1] = mk(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 8'd3, 8'h3C, 8'h12, 8'h34, 8'h56, 8'h3C);
    vecs[2] = mk(8'hFE, 8'h01, 8'h80, 8'h7F, 1'b0, 8'd0, 8'h00, 8'hFE, 8'h01, 8'h80, 8'h7F);

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(bus.tx), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_mem_addr", int'(bus.mem_addr), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 3; v++) run_vec(v);

    // start held high through a whole dump: one dump, then re-accepted after DONE.
    base = rx_q.size();
    dc0  = done_cnt;
    load_ram(0);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk);
    observe(-1, 8'd0, 8'h00, fall_k, done_k, bd);
    chk("hold_tx_fall1", fall_k, FALL_K);
    chk("hold_done1", done_k, DONE_K);
    chk("hold_rx_count1", rx_q.size() - base, NB);
    @(negedge clk);
    chk("hold_idle_busy", int'(bus.busy), 0);
    @(negedge clk);
    chk("hold_restart_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    observe(-1, 8'd0, 8'h00, fall_k, done_k, bd);
    chk("hold_tx_fall2", fall_k, FALL_K);
    chk("hold_done2", done_k, DONE_K);
    @(negedge clk);
    chk("hold_done_count", done_cnt - dc0, 2);
    chk("hold_rx_count", rx_q.size() - base, 2 * NB);
    check_bytes(0, base, NB);
    check_bytes(0, base + NB, NB);

    // Reset in the middle of a data frame aborts with no done pulse.
    base = rx_q.size();
    dc0  = done_cnt;
    load_ram(2);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (RST_K) @(negedge clk);
    chk("pre_reset_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx", int'(bus.tx), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_mem_addr", int'(bus.mem_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DONE_K) @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_idle_busy", int'(bus.busy), 0);
    chk("abort_rx_count", rx_q.size() - base, 2);
    check_bytes(2, base, 2);

    // Fresh dump after the abort starts again from address 0.
    run_vec(0);

    chk("frame_errors", frame_bad, 0);
    chk("max_mem_addr", int'(max_addr), D - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dump_uart.md
# ram_dump_uart

Read-side companion to the CPU's byte-wide data RAM: on a start pulse it sequentially reads RAM bytes 0 to DEPTH-1 through a dedicated synchronous read port and transmits each byte over a UART TX line (8N1, LSB first). It sits beside the processor top level, alongside the VGA path, and gives the bench and the board a serial dump of what the program wrote into data memory.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200). Legal range is 2..65535.
- DEPTH, default 65: number of RAM bytes dumped, at addresses 0..DEPTH-1. Legal range is 1..256.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a dump. It is sampled only in IDLE.
- mem_addr  out  8  RAM read address.
- mem_rdata  in  8  RAM read data. It is valid one clk after mem_addr is presented (registered RAM).
- tx  out  1  UART serial output. Idle level is 1.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses, inclusive.
- done  out  1  one-cycle pulse after the last stop bit completes.

## Operation
- States: IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE:
  - tx=1, busy=0, mem_addr holds its last value.
  - start=1 moves to FETCH with the address counter cleared to 0 (or to header mode, see Configuration).
- FETCH: drives mem_addr = address counter for one cycle, then goes to LOAD.
- LOAD: captures mem_rdata into an 8-bit shift register, then goes to START_BIT.
- START_BIT:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then DATA_BITS with the bit index at 0.
- DATA_BITS:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit.
  - After 8 bits, goes to STOP_BIT.
- STOP_BIT:
  - tx=1 for CLKS_PER_BIT cycles.
  - If the address counter equals DEPTH-1, goes to DONE.
  - Otherwise increments the address counter and goes to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - The address counter is 8 bits and never wraps, because it stops at DEPTH-1.
  - The baud counter is 16 bits. It counts 0..CLKS_PER_BIT-1 and clears on every state change.
- start outside IDLE is ignored; it is neither queued nor used to restart.
- start asserted in the same cycle as DONE is ignored. start is accepted in the following IDLE cycle only if it is still high.
- mem_rdata is sampled only in LOAD. RAM writes by the CPU during a dump are allowed, and each byte reflects RAM contents at its own LOAD cycle.

## Timing
- Reset values: state=IDLE, tx=1, busy=0, done=0, mem_addr=0, all counters 0, shift register 0.
- Reset mid-operation aborts the current frame. tx returns to 1 in the cycle after the reset edge, and no done pulse is produced.
- Latency from the start-accepted edge to tx falling: 2 cycles (FETCH, LOAD).
- One byte occupies 2 + 10*CLKS_PER_BIT cycles.
- A full dump of N transmitted bytes takes N*(2 + 10*CLKS_PER_BIT) cycles, followed by the done cycle.
- Between stop bit and next start bit, tx stays 1 for exactly 2 cycles (FETCH, LOAD).

## Configuration
- DUMP_HEADER_EN defined:
  - Each dump is prefixed by two framed bytes: sync 0xA5, then the length byte DEPTH[7:0]. A DEPTH of 256 sends 0x00.
  - The header bytes bypass FETCH and LOAD: they are loaded straight into the shift register from a 2-state header sub-sequence, each costing 1 load cycle plus the frame.
  - The address counter starts at 0 after the header.
- DUMP_HEADER_EN undefined: only the DEPTH RAM bytes are sent. No header logic is synthesized.

## Test plan
Bench uses CLKS_PER_BIT=4, DEPTH=4, a behavioural registered RAM model, and a UART RX checker.
- RAM={0x55,0x00,0xFF,0x81}, pulse start (no header):
  - The checker decodes 0x55, 0x00, 0xFF, 0x81 in order.
  - tx falls 2 cycles after start is accepted.
  - done pulses exactly once, 4*42 cycles after acceptance.
- start held high for the whole first dump:
  - Exactly one dump of 4 bytes is sent.
  - A second dump begins in the IDLE cycle after DONE.
- reset asserted mid-DATA_BITS of byte 2:
  - tx=1 and busy=0 the next cycle; no done pulse.
  - A subsequent start dumps from address 0 again.
- CPU write of 0x3C to address 3 while byte 1 is being transmitted: byte 3 is received as 0x3C.
- DUMP_HEADER_EN defined, DEPTH=4: the checker decodes 0xA5, 0x04, then the 4 RAM bytes, and done follows the 6th stop bit.
- Stop-bit check: every frame's stop bit is 1 for 4 cycles, and mem_addr never exceeds 3.
